// File: rtl/arbiter_grant_holder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arbiter_grant_holder_pkg
//  Description : Shared state encodings and hold-counter sizing helper.
//  Revision    : 1.0 - initial release
// ============================================================================

package arbiter_grant_holder_pkg;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_HELD = 1'b1;

    // Counter must reach max_hold-1; keep at least one bit for tiny limits.
    function automatic int hold_cnt_width(input int max_hold);
        if (max_hold <= 2) begin
            return 1;
        end
        return $clog2(max_hold);
    endfunction

endpackage

`default_nettype wire

// File: rtl/arbiter_grant_holder_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : Priority_Arbiter
//  Description : Fixed-priority picker, least-significant set bit wins.
//  Revision    : 1.0 - initial release
// ============================================================================

module Priority_Arbiter #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] i_requests,
    output logic [WIDTH-1:0] o_grant
);

    // Two's-complement trick isolates the lowest set bit.
    assign o_grant = i_requests & (~i_requests + WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/arbiter_grant_holder.sv
`default_nettype none
// ============================================================================
//  Module      : arbiter_grant_holder
//  Description : Non-preemptive fixed-priority arbiter that holds a grant for
//                the whole transaction. Optional hold timeout enabled by macro
//                ARBITER_GRANT_HOLDER_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================

module arbiter_grant_holder
    import arbiter_grant_holder_pkg::*;
#(
    parameter int WORD_WIDTH      = 0,
    parameter int MAX_HOLD_CYCLES = 16,
    localparam int c_W = (WORD_WIDTH < 1) ? 1 : WORD_WIDTH
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [c_W-1:0] requests,
    output logic [c_W-1:0] grant,
    output logic           busy,
    output logic           timeout
);

    logic [0:0]     r_state;
    logic [0:0]     w_state_nxt;
    logic [c_W-1:0] r_grant;
    logic [c_W-1:0] w_grant_nxt;
    logic           r_busy;
    logic           w_load;
    logic           w_held;
    logic           w_fire;
    logic [c_W-1:0] w_lockout;
    logic [c_W-1:0] w_arb_in;
    logic [c_W-1:0] w_cand;

    assign w_held = |(requests & r_grant);

    // A revoked requestor is masked out of the same-cycle re-arbitration.
    assign w_arb_in = requests & ~w_lockout & ~(w_fire ? r_grant : '0);

    Priority_Arbiter #(
        .WIDTH      (c_W)
    ) u_pick (
        .i_requests (w_arb_in),
        .o_grant    (w_cand)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= c_ST_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_busy  <= (w_state_nxt == c_ST_HELD);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_load      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (|w_cand) begin
                    w_state_nxt = c_ST_HELD;
                    w_grant_nxt = w_cand;
                    w_load      = 1'b1;
                end else begin
                    w_grant_nxt = '0;
                end
            end
            c_ST_HELD: begin
                // Timeout outranks an ongoing hold; otherwise no preemption.
                if (w_fire || !w_held) begin
                    w_load      = 1'b1;
                    w_grant_nxt = w_cand;
                    w_state_nxt = (|w_cand) ? c_ST_HELD : c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

`ifdef ARBITER_GRANT_HOLDER_TIMEOUT_EN
    localparam int c_CNT_W = hold_cnt_width(MAX_HOLD_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_HOLD_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;
    logic [c_W-1:0]     r_lockout;
    logic               r_timeout;

    assign w_fire    = (r_state == c_ST_HELD) && w_held && (r_count == c_CNT_LAST);
    assign w_lockout = r_lockout;
    assign timeout   = r_timeout;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_count   <= '0;
            r_lockout <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_load) begin
                r_count <= '0;
            end else if (r_state == c_ST_HELD) begin
                r_count <= r_count + c_CNT_W'(1);
            end
            // Lockout releases once the requestor is seen deasserted.
            r_lockout <= (r_lockout & requests) | (w_fire ? r_grant : '0);
            r_timeout <= w_fire;
        end
    end
`else
    assign w_fire    = 1'b0;
    assign w_lockout = '0;
    assign timeout   = 1'b0;
`endif

    assign grant = r_grant;
    assign busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_arbiter_grant_holder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arbiter_grant_holder
//  Description : Scoreboard bench for arbiter_grant_holder (4 requestors).
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_arbiter_grant_holder;

    typedef struct packed {
        logic [3:0] g;
        logic       b;
        logic       t;
    } exp_t;

    logic       clock = 1'b0;
    logic       clear;
    logic [3:0] requests;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_exp[$];

    arbiter_grant_holder #(
        .WORD_WIDTH      (4),
        .MAX_HOLD_CYCLES (8)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .requests (requests),
        .grant    (grant),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus; expected outputs after the edge go to the queue.
    task automatic step(input logic [3:0] req, input logic clr,
                        input logic [3:0] eg, input logic eb, input logic et);
        exp_t e;
        requests = req;
        clear    = clr;
        q_exp.push_back('{g: eg, b: eb, t: et});
        @(posedge clock);
        #1;
        e = q_exp.pop_front();
        check("grant",   {28'd0, grant},   {28'd0, e.g});
        check("busy",    {31'd0, busy},    {31'd0, e.b});
        check("timeout", {31'd0, timeout}, {31'd0, e.t});
        check("onehot0", {31'd0, $onehot0(grant)}, 32'd1);
    endtask

    initial begin
        requests = 4'b0000;
        clear    = 1'b1;

        // Reset dominates active requests
        repeat (3) step(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

        // No preemption by a higher-priority newcomer
        step(4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0);
        repeat (3) step(4'b0101, 1'b0, 4'b0100, 1'b1, 1'b0);
        step(4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

        // Handover to idle
        repeat (5) step(4'b1000, 1'b0, 4'b1000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

        // Granted bit drops as higher bits rise
        step(4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0);
        step(4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0);
        step(4'b1100, 1'b0, 4'b0100, 1'b1, 1'b0);
        step(4'b1000, 1'b0, 4'b1000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

        // Drop and re-raise is a fresh request, re-arbitrated
        step(4'b0011, 1'b0, 4'b0001, 1'b1, 1'b0);
        step(4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0);
        step(4'b0011, 1'b0, 4'b0010, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

`ifdef ARBITER_GRANT_HOLDER_TIMEOUT_EN
        repeat (8) step(4'b0011, 1'b0, 4'b0001, 1'b1, 1'b0);
        step(4'b0011, 1'b0, 4'b0010, 1'b1, 1'b1);
        step(4'b0011, 1'b0, 4'b0010, 1'b1, 1'b0);
        // Bit 0 still locked out while it stays high
        step(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
`else
        repeat (12) step(4'b0011, 1'b0, 4'b0001, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
`endif

        // Clear aborts an in-flight transaction
        step(4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
